// File: rtl/sync_updown_counter.sv
// Parametrised up/down counter with enable, clamped parallel load and a wrap-or-saturate boundary.
// Outputs a combinational terminal-count flag, a one-cycle wrap pulse and a sticky overflow flag.
module sync_updown_counter #(
  parameter int unsigned      WIDTH    = 3,
  parameter logic [WIDTH-1:0] MAX_VAL  = WIDTH'((64'd1 << WIDTH) - 64'd1),
  parameter bit               SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] din_clamped;
  logic             at_bound;

  assign at_bound    = up ? (q_q == MAX_VAL) : (q_q == '0);
  assign din_clamped = (din > MAX_VAL) ? MAX_VAL : din;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (load) begin
      q_d = din_clamped;
    end else if (en) begin
      if (at_bound) begin
        // A boundary count sets ovf even when saturating: the count is lost.
        ovf_d = 1'b1;
        if (!SATURATE) begin
          wrap_d = 1'b1;
          q_d    = up ? '0 : MAX_VAL;
        end
      end else begin
        q_d = up ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q    <= RST_VAL;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign q    = q_q;
  assign tc   = at_bound;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;

endmodule
